// File: rtl/fsm_share_arb_pkg.sv
// ---------------------------------------------------------------------------
// fsm_share_arb_pkg
//   Shared definitions for the round-robin arbiter that time-shares one
//   Mealy control FSM between several requesters.
//   Contents: arbiter state encoding, default parameter values and a
//   modulo-increment helper used by the round-robin picker.
// ---------------------------------------------------------------------------
package fsm_share_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      CLEAR = 2'd2
   } arb_state_e;

   localparam int NREQ_DEF  = 4;
   localparam int BURST_DEF = 4;
   localparam int CNT_W_DEF = 8;

   // Next requester index after i, wrapping at n.
   function automatic int wrap_inc(input int i, input int n);
      return (i + 1 >= n) ? 0 : i + 1;
   endfunction

endpackage

// File: rtl/fsm_share_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Searches the request vector starting
//   one position after rr_ptr (wrapping) and returns the first requester.
// Ports
//   req     in  NREQ   request vector
//   rr_ptr  in  PTR_W  index of the most recently served requester
//   win     out NREQ   one-hot winner (zero when no request)
//   win_idx out PTR_W  binary index of the winner
//   valid   out 1      at least one request present
// ---------------------------------------------------------------------------
module rr_pick
   import fsm_share_arb_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int PTR_W = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic [NREQ-1:0]  win,
   output logic [PTR_W-1:0] win_idx,
   output logic             valid
);

   int idx;

   always_comb begin
      win     = '0;
      win_idx = '0;
      valid   = 1'b0;
      idx     = int'(rr_ptr);
      // NREQ steps visit every requester once, ending on rr_ptr itself so
      // the last-served requester has the lowest priority.
      for (int k = 0; k < NREQ; k++) begin
         idx = wrap_inc(idx, NREQ);
         if (!valid && req[idx]) begin
            valid    = 1'b1;
            win[idx] = 1'b1;
            win_idx  = PTR_W'(idx);
         end
      end
   end

endmodule

// File: rtl/fsm_share_arb.sv
// ---------------------------------------------------------------------------
// fsm_share_arb
//   Round-robin arbiter sharing one two-input Mealy control FSM (inputs a,b;
//   outputs m,n) between NREQ requesters. An owner holds the FSM for at most
//   BURST cycles; between owners the FSM is returned to its start state by a
//   one-cycle registered low pulse on fsm_rst_b.
// Optional feature
//   ARB_STATS_EN : per-requester saturating grant counters on gnt_cnt.
//                  When undefined gnt_cnt is tied to zero (no flops).
// Ports
//   clk, rst_b        clock (rising edge), async active-low reset
//   req[NREQ]         requests, held high while the FSM is wanted
//   a_in/b_in[NREQ]   per-requester FSM inputs
//   fsm_m, fsm_n      shared FSM outputs
//   fsm_a, fsm_b      shared FSM inputs (owner's a/b, zero when no grant)
//   fsm_rst_b         registered active-low reset to the shared FSM
//   gnt[NREQ]         registered one-hot grant
//   m_o/n_o[NREQ]     FSM outputs routed to the owner (combinational)
//   gnt_cnt           grant counters, requester i at [i*CNT_W +: CNT_W]
// ---------------------------------------------------------------------------
module fsm_share_arb
   import fsm_share_arb_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int BURST = BURST_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_b,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0]       a_in,
   input  logic [NREQ-1:0]       b_in,
   input  logic                  fsm_m,
   input  logic                  fsm_n,
   output logic                  fsm_a,
   output logic                  fsm_b,
   output logic                  fsm_rst_b,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       m_o,
   output logic [NREQ-1:0]       n_o,
   output logic [NREQ*CNT_W-1:0] gnt_cnt
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int BC_W  = (BURST > 1) ? $clog2(BURST) : 1;

   arb_state_e       state, state_nxt;
   logic [PTR_W-1:0] owner;
   logic [PTR_W-1:0] rr_ptr;
   logic [BC_W-1:0]  burst_cnt;

   logic [NREQ-1:0]  pick_win;
   logic [PTR_W-1:0] pick_idx;
   logic             pick_vld;
   logic             owner_req;
   logic             burst_last;

   rr_pick #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req     (req),
      .rr_ptr  (rr_ptr),
      .win     (pick_win),
      .win_idx (pick_idx),
      .valid   (pick_vld)
   );

   assign owner_req  = req[owner];
   assign burst_last = (burst_cnt == BC_W'(BURST - 1));

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_vld) state_nxt = GRANT;
         GRANT:   if (!owner_req || burst_last) state_nxt = CLEAR;
         CLEAR:   state_nxt = pick_vld ? GRANT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State, ownership and registered outputs
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state     <= IDLE;
         owner     <= '0;
         rr_ptr    <= PTR_W'(NREQ - 1);
         burst_cnt <= '0;
         gnt       <= '0;
         fsm_rst_b <= 1'b0;
      end else begin
         state     <= state_nxt;
         // Low for exactly the CLEAR cycle; registered so the shared FSM
         // never sees a combinational glitch on its reset.
         fsm_rst_b <= (state_nxt != CLEAR);
         case (state_nxt)
            GRANT: begin
               if (state != GRANT) begin
                  owner     <= pick_idx;
                  gnt       <= pick_win;
                  burst_cnt <= '0;
               end else begin
                  burst_cnt <= burst_cnt + 1'b1;
               end
            end
            CLEAR: begin
               gnt       <= '0;
               burst_cnt <= '0;
               // Updating here means the CLEAR-cycle pick already sees the
               // departing owner as lowest priority.
               if (state == GRANT) rr_ptr <= owner;
            end
            default: begin
               gnt       <= '0;
               burst_cnt <= '0;
            end
         endcase
      end
   end

   // gnt is only nonzero in GRANT, so gating by gnt also forces the FSM
   // inputs to zero (asynchronously on reset) whenever nobody owns it.
   assign fsm_a = |(gnt & a_in & req);
   assign fsm_b = |(gnt & b_in & req);

   // Mealy outputs stay combinational from the shared FSM to the owner.
   assign m_o = gnt & {NREQ{fsm_m}};
   assign n_o = gnt & {NREQ{fsm_n}};

`ifdef ARB_STATS_EN
   logic             grant_start;
   logic [CNT_W-1:0] cnt_q [NREQ];

   assign grant_start = (state_nxt == GRANT) && (state != GRANT);

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
      end else if (grant_start) begin
         for (int i = 0; i < NREQ; i++) begin
            if (pick_win[i] && (cnt_q[i] != {CNT_W{1'b1}}))
               cnt_q[i] <= cnt_q[i] + 1'b1;
         end
      end
   end

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt
      assign gnt_cnt[gi*CNT_W +: CNT_W] = cnt_q[gi];
   end
`else
   assign gnt_cnt = '0;
`endif

endmodule

// File: tb/tb_fsm_share_arb.sv
// ---------------------------------------------------------------------------
// tb_fsm_share_arb
//   Randomized bench for fsm_share_arb (NREQ=4, BURST=4, CNT_W=8) with a
//   small Mealy FSM standing in for the shared controller. A per-cycle
//   reference model of the arbitration rules pushes expected outputs into a
//   queue; a monitor pops one entry after each rising edge and compares.
// ---------------------------------------------------------------------------
module tb_fsm_share_arb;

   localparam int NREQ  = 4;
   localparam int BURST = 4;
   localparam int CNT_W = 8;

   logic              clk   = 1'b0;
   logic              rst_b = 1'b1;
   logic [NREQ-1:0]   req   = '0;
   logic [NREQ-1:0]   a_in  = '0;
   logic [NREQ-1:0]   b_in  = '0;
   logic              fsm_m, fsm_n, fsm_a, fsm_b, fsm_rst_b;
   logic [NREQ-1:0]   gnt, m_o, n_o;
   logic [NREQ*CNT_W-1:0] gnt_cnt;

   always #5 clk = ~clk;

   fsm_share_arb #(.NREQ(NREQ), .BURST(BURST), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .req       (req),
      .a_in      (a_in),
      .b_in      (b_in),
      .fsm_m     (fsm_m),
      .fsm_n     (fsm_n),
      .fsm_a     (fsm_a),
      .fsm_b     (fsm_b),
      .fsm_rst_b (fsm_rst_b),
      .gnt       (gnt),
      .m_o       (m_o),
      .n_o       (n_o),
      .gnt_cnt   (gnt_cnt)
   );

   // Shared Mealy FSM: toggles on a, m = a & s, n = b ^ s.
   logic fs;
   always_ff @(posedge clk or negedge fsm_rst_b) begin
      if (!fsm_rst_b) fs <= 1'b0;
      else if (fsm_a) fs <= ~fs;
   end
   assign fsm_m = fsm_a & fs;
   assign fsm_n = fsm_b ^ fs;

   typedef struct packed {
      logic [NREQ-1:0]       gnt;
      logic                  frst;
      logic                  a;
      logic                  b;
      logic [NREQ*CNT_W-1:0] cnt;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_vec = 0;
   int   n_err = 0;
   bit   rel_pending = 1'b0;

   // Reference model: who owns the FSM, how many cycles used, who was last.
   bit m_busy, m_gap;
   int m_owner, m_used, m_last;
   int m_cnt[NREQ];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy  = 1'b0;
      m_gap   = 1'b0;
      m_owner = 0;
      m_used  = 0;
      m_last  = NREQ - 1;
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
   endtask

   task automatic model_step(input logic [NREQ-1:0] r);
      bit found;
      if (m_busy) begin
         if (!r[m_owner] || m_used == BURST) begin
            m_busy = 1'b0;
            m_gap  = 1'b1;
            m_last = m_owner;
         end else begin
            m_used++;
         end
      end else begin
         m_gap = 1'b0;
         if (r != 0) begin
            found = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
               if (!found && r[(m_last + k) % NREQ]) begin
                  found   = 1'b1;
                  m_owner = (m_last + k) % NREQ;
               end
            end
            m_busy = 1'b1;
            m_used = 1;
            if (m_cnt[m_owner] < (1 << CNT_W) - 1) m_cnt[m_owner]++;
         end
      end
   endtask

   // One stimulus cycle: drive at the falling edge, predict post-edge state.
   task automatic cyc(input logic [NREQ-1:0] r, input logic [NREQ-1:0] a, input logic [NREQ-1:0] b);
      exp_t x;
      @(negedge clk);
      if (rel_pending) begin
         rst_b       = 1'b1;
         rel_pending = 1'b0;
      end
      req  = r;
      a_in = a;
      b_in = b;
      model_step(r);
      x.gnt  = m_busy ? NREQ'(1 << m_owner) : '0;
      x.frst = !m_gap;
      x.a    = m_busy && a[m_owner] && r[m_owner];
      x.b    = m_busy && b[m_owner] && r[m_owner];
      x.cnt  = '0;
`ifdef ARB_STATS_EN
      for (int i = 0; i < NREQ; i++) x.cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
`endif
      sb.push_back(x);
   endtask

   // Asynchronous reset in the middle of a clock period.
   task automatic mid_reset();
      @(posedge clk);
      #3;
      a_in  = '1;
      b_in  = '1;
      rst_b = 1'b0;
      #1;
      chk("async_rst_gnt", 32'(gnt), 32'h0);
      chk("async_rst_fsm_a", 32'(fsm_a), 32'h0);
      chk("async_rst_fsm_b", 32'(fsm_b), 32'h0);
      chk("async_rst_fsm_rst_b", 32'(fsm_rst_b), 32'h0);
      chk("async_rst_cnt", gnt_cnt, 32'h0);
      repeat (2) @(negedge clk);
      model_reset();
      rel_pending = 1'b1;
   endtask

   // Monitor: one expected entry per rising edge while stimulus is active.
   always @(posedge clk) begin
      #1;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("gnt", 32'(gnt), 32'(e.gnt));
         chk("fsm_rst_b", 32'(fsm_rst_b), 32'(e.frst));
         chk("fsm_a", 32'(fsm_a), 32'(e.a));
         chk("fsm_b", 32'(fsm_b), 32'(e.b));
         chk("m_o", 32'(m_o), 32'(e.gnt & {NREQ{fsm_m}}));
         chk("n_o", 32'(n_o), 32'(e.gnt & {NREQ{fsm_n}}));
         chk("gnt_cnt", gnt_cnt, e.cnt);
      end
   end

   logic [NREQ-1:0] r_rand;

   initial begin
      model_reset();
      req = 4'b1111;
      #1 rst_b = 1'b0;
      #1;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_fsm_rst_b", 32'(fsm_rst_b), 32'h0);
      chk("rst_fsm_a", 32'(fsm_a), 32'h0);
      chk("rst_cnt", gnt_cnt, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold_gnt", 32'(gnt), 32'h0);
      chk("rst_hold_fsm_rst_b", 32'(fsm_rst_b), 32'h0);
      rel_pending = 1'b1;

      // All requesting at release, then sole requester 0 with a/b 1,1 then 0,0.
      cyc(4'b1111, 4'b0001, 4'b0001);
      for (int i = 0; i < 6; i++)  cyc(4'b0001, 4'b1111, 4'b1111);
      for (int i = 0; i < 8; i++)  cyc(4'b0001, 4'b0000, 4'b0000);
      // Everyone requesting: full rotation.
      for (int i = 0; i < 25; i++) cyc(4'b1111, 4'($urandom), 4'($urandom));

      // Owner 2 drops after two granted cycles; 3 is waiting.
      mid_reset();
      cyc(4'b1100, 4'b0100, 4'b0000);
      cyc(4'b1100, 4'b0000, 4'b0100);
      cyc(4'b1000, 4'b1111, 4'b1111);
      for (int i = 0; i < 8; i++) cyc(4'b1000, 4'($urandom), 4'($urandom));

      // Sticky random requests.
      r_rand = 4'($urandom);
      for (int i = 0; i < 400; i++) begin
         for (int j = 0; j < NREQ; j++)
            if ($urandom_range(0, 7) == 0) r_rand[j] = ~r_rand[j];
         cyc(r_rand, 4'($urandom), 4'($urandom));
      end

      // Reset while requester 0 is mid-burst.
      mid_reset();
      for (int i = 0; i < 3; i++) cyc(4'b0001, 4'b0001, 4'b0001);
      mid_reset();

      // Long run of grants to requester 0 (counter saturation when enabled).
      for (int i = 0; i < 1560; i++) cyc(4'b0001, 4'($urandom), 4'($urandom));

      @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(sb.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
